// File: rtl/pc_gen_unit_if.sv
// ---------------------------------------------------------------------------
// pc_gen_unit_if
// Bundles the signals between the next-PC generator and its neighbours
// (hazard unit, execute stage, fetch).
//   master : drives the execute/hazard-side controls, observes fetch outputs
//   slave  : the PC generator itself
// Execute/hazard side : Stall_F, PCSrc_E, PCTarget_E, PCJALR_E, Trap_E,
//                       RasPush_E, RasPop_E, PCPlus4_E
// Fetch side          : PC_F, PCPlus4_F, Flush_o, RasTop_F, RasValid_F,
//                       Misalign_o, RedirectCnt_o
// ---------------------------------------------------------------------------
interface pc_gen_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             Stall_F;
  logic [1:0]       PCSrc_E;
  logic [XLEN-1:0]  PCTarget_E;
  logic [XLEN-1:0]  PCJALR_E;
  logic             Trap_E;
  logic             RasPush_E;
  logic             RasPop_E;
  logic [XLEN-1:0]  PCPlus4_E;

  logic [XLEN-1:0]  PC_F;
  logic [XLEN-1:0]  PCPlus4_F;
  logic             Flush_o;
  logic [XLEN-1:0]  RasTop_F;
  logic             RasValid_F;
  logic             Misalign_o;
  logic [CNT_W-1:0] RedirectCnt_o;

  modport master (
    output Stall_F, PCSrc_E, PCTarget_E, PCJALR_E, Trap_E,
           RasPush_E, RasPop_E, PCPlus4_E,
    input  PC_F, PCPlus4_F, Flush_o, RasTop_F, RasValid_F,
           Misalign_o, RedirectCnt_o
  );

  modport slave (
    input  Stall_F, PCSrc_E, PCTarget_E, PCJALR_E, Trap_E,
           RasPush_E, RasPop_E, PCPlus4_E,
    output PC_F, PCPlus4_F, Flush_o, RasTop_F, RasValid_F,
           Misalign_o, RedirectCnt_o
  );
endinterface

// File: rtl/pc_gen_unit.sv
// ---------------------------------------------------------------------------
// pc_gen_unit
// Fetch-stage next-PC generator. Owns the PC register, picks the next PC
// from sequential / branch-JAL / JALR / trap sources, raises the pipeline
// flush request, keeps a small return-address stack and a saturating
// redirect counter.
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pc_gen_unit_if slave modport (control inputs from the execute
//           stage and hazard unit, PC/RAS/status outputs to fetch)
// ---------------------------------------------------------------------------
module pc_gen_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
  parameter int              RAS_DEPTH = 4,
  parameter int              CNT_W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  pc_gen_unit_if.slave bus
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CW    = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  pcPlus4;
  logic             misalign_q;
  logic [CNT_W-1:0] redirCnt_q, redirCnt_d;
  logic [XLEN-1:0]  rasMem_q [RAS_DEPTH];
  logic [PTR_W-1:0] rasPtr_q, rasPtr_d;
  logic [PTR_W-1:0] rasTopIdx;
  logic [CW-1:0]    rasCnt_q, rasCnt_d;
  logic             rasWrEn;
  logic [PTR_W-1:0] rasWrIdx;
  logic             isTarget, isJalr, flush;

  // PCSrc_E=11 is reserved and behaves like sequential, so it never flushes.
  assign isTarget  = (bus.PCSrc_E == 2'b01);
  assign isJalr    = (bus.PCSrc_E == 2'b10);
  assign flush     = bus.Trap_E | isTarget | isJalr;
  assign pcPlus4   = pc_q + XLEN'(4);
  assign rasTopIdx = rasPtr_q - PTR_W'(1);

  // Next-PC select: redirects beat the stall so a taken branch is never lost.
  always_comb begin
    pc_d = pcPlus4;
    if (bus.Trap_E) begin
      pc_d = TRAP_VEC;
    end else if (isTarget) begin
      pc_d = bus.PCTarget_E;
    end else if (isJalr) begin
      pc_d = {bus.PCJALR_E[XLEN-1:1], 1'b0};
    end else if (bus.Stall_F) begin
      pc_d = pc_q;
    end
  end

  always_comb begin
    redirCnt_d = redirCnt_q;
    if (flush && (redirCnt_q != '1)) begin
      redirCnt_d = redirCnt_q + CNT_W'(1);
    end
  end

  // RAS bookkeeping. A simultaneous push and pop (co-routine swap) rewrites
  // the current top in place; on an empty stack it degenerates to a push.
  always_comb begin
    rasPtr_d = rasPtr_q;
    rasCnt_d = rasCnt_q;
    rasWrEn  = 1'b0;
    rasWrIdx = rasPtr_q;
    if (bus.RasPush_E && bus.RasPop_E && (rasCnt_q != '0)) begin
      rasWrEn  = 1'b1;
      rasWrIdx = rasTopIdx;
    end else if (bus.RasPush_E) begin
      rasWrEn  = 1'b1;
      rasPtr_d = rasPtr_q + PTR_W'(1);
      if (rasCnt_q != FULL_CNT) begin
        rasCnt_d = rasCnt_q + CW'(1);
      end
    end else if (bus.RasPop_E && (rasCnt_q != '0)) begin
      rasPtr_d = rasTopIdx;
      rasCnt_d = rasCnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
      redirCnt_q <= '0;
      rasPtr_q   <= '0;
      rasCnt_q   <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        rasMem_q[i] <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      misalign_q <= pc_d[1];
      redirCnt_q <= redirCnt_d;
      rasPtr_q   <= rasPtr_d;
      rasCnt_q   <= rasCnt_d;
      if (rasWrEn) begin
        rasMem_q[rasWrIdx] <= bus.PCPlus4_E;
      end
    end
  end

  assign bus.PC_F          = pc_q;
  assign bus.PCPlus4_F     = pcPlus4;
  assign bus.Flush_o       = flush;
  assign bus.RasTop_F      = (rasCnt_q != '0) ? rasMem_q[rasTopIdx] : '0;
  assign bus.RasValid_F    = (rasCnt_q != '0);
  assign bus.Misalign_o    = misalign_q;
  assign bus.RedirectCnt_o = redirCnt_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_gen_unit
// Drives two pc_gen_unit instances (16-bit and 2-bit redirect counters) from
// the same stimulus and compares them every cycle against a behavioural
// model: a plain PC variable, a bounded queue standing in for the RAS, and
// saturating integer counters.
// ---------------------------------------------------------------------------
module tb_pc_gen_unit;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
  localparam int          RAS_DEPTH = 4;

  logic clk;
  logic rst_n;
  int   checkCount = 0;
  int   passCount  = 0;
  bit   compareEn  = 0;

  // Behavioural model state
  logic [31:0] mPc;
  logic        mMis;
  int          mCnt;
  int          mCnt2;
  logic [31:0] mRas[$];

  pc_gen_unit_if #(.XLEN(32), .CNT_W(16)) bus ();
  pc_gen_unit_if #(.XLEN(32), .CNT_W(2))  bus2 ();

  assign bus2.Stall_F    = bus.Stall_F;
  assign bus2.PCSrc_E    = bus.PCSrc_E;
  assign bus2.PCTarget_E = bus.PCTarget_E;
  assign bus2.PCJALR_E   = bus.PCJALR_E;
  assign bus2.Trap_E     = bus.Trap_E;
  assign bus2.RasPush_E  = bus.RasPush_E;
  assign bus2.RasPop_E   = bus.RasPop_E;
  assign bus2.PCPlus4_E  = bus.PCPlus4_E;

  pc_gen_unit #(
    .XLEN(32), .RESET_VEC(RESET_VEC), .TRAP_VEC(TRAP_VEC),
    .RAS_DEPTH(RAS_DEPTH), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  pc_gen_unit #(
    .XLEN(32), .RESET_VEC(RESET_VEC), .TRAP_VEC(TRAP_VEC),
    .RAS_DEPTH(RAS_DEPTH), .CNT_W(2)
  ) dutSmall (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mPc   = RESET_VEC;
    mMis  = 1'b0;
    mCnt  = 0;
    mCnt2 = 0;
    mRas.delete();
  endtask

  task automatic applyStimulus(input logic stall, input logic [1:0] src,
                               input logic [31:0] target, input logic [31:0] jalr,
                               input logic trap, input logic push, input logic pop,
                               input logic [31:0] link);
    bus.Stall_F    = stall;
    bus.PCSrc_E    = src;
    bus.PCTarget_E = target;
    bus.PCJALR_E   = jalr;
    bus.Trap_E     = trap;
    bus.RasPush_E  = push;
    bus.RasPop_E   = pop;
    bus.PCPlus4_E  = link;
  endtask

  // Advance one clock: work out what the spec says happens on this edge from
  // the inputs currently applied, then commit it at the edge.
  task automatic step();
    logic [31:0] nPc;
    bit          redirect;
    redirect = bus.Trap_E || (bus.PCSrc_E == 2'b01) || (bus.PCSrc_E == 2'b10);
    if (bus.Trap_E)                nPc = TRAP_VEC;
    else if (bus.PCSrc_E == 2'b01) nPc = bus.PCTarget_E;
    else if (bus.PCSrc_E == 2'b10) nPc = bus.PCJALR_E & 32'hFFFF_FFFE;
    else if (bus.Stall_F)          nPc = mPc;
    else                           nPc = mPc + 32'd4;
    @(posedge clk);
    mPc  = nPc;
    mMis = nPc[1];
    if (redirect) begin
      mCnt  = (mCnt  < 65535) ? mCnt + 1  : 65535;
      mCnt2 = (mCnt2 < 3)     ? mCnt2 + 1 : 3;
    end
    if (bus.RasPush_E && bus.RasPop_E && (mRas.size() > 0)) begin
      mRas[mRas.size()-1] = bus.PCPlus4_E;
    end else if (bus.RasPush_E) begin
      mRas.push_back(bus.PCPlus4_E);
      if (mRas.size() > RAS_DEPTH) void'(mRas.pop_front());
    end else if (bus.RasPop_E && (mRas.size() > 0)) begin
      void'(mRas.pop_back());
    end
    #1;
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async reset PC_F", bus.PC_F, RESET_VEC);
    checkOutput("async reset RasValid_F", 32'(bus.RasValid_F), 32'd0);
    checkOutput("async reset RedirectCnt_o", 32'(bus.RedirectCnt_o), 32'd0);
    #3;
    rst_n = 1'b1;
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (compareEn) begin
      checkOutput("PC_F", bus.PC_F, mPc);
      checkOutput("PCPlus4_F", bus.PCPlus4_F, mPc + 32'd4);
      checkOutput("Flush_o", 32'(bus.Flush_o),
                  32'(bus.Trap_E || (bus.PCSrc_E == 2'b01) || (bus.PCSrc_E == 2'b10)));
      checkOutput("RasTop_F", bus.RasTop_F,
                  (mRas.size() > 0) ? mRas[mRas.size()-1] : 32'd0);
      checkOutput("RasValid_F", 32'(bus.RasValid_F), 32'(mRas.size() > 0));
      checkOutput("Misalign_o", 32'(bus.Misalign_o), 32'(mMis));
      checkOutput("RedirectCnt_o", 32'(bus.RedirectCnt_o), 32'(mCnt));
      checkOutput("RedirectCnt_o small", 32'(bus2.RedirectCnt_o), 32'(mCnt2));
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0);
    modelReset();
    #1 rst_n = 1'b0;
    #1 compareEn = 1;
    #10 rst_n = 1'b1;
    #1;

    // Reset state and free run
    checkOutput("reset PC_F", bus.PC_F, 32'h0);
    checkOutput("reset Flush_o", 32'(bus.Flush_o), 32'd0);
    checkOutput("reset RasTop_F", bus.RasTop_F, 32'h0);
    checkOutput("reset Misalign_o", 32'(bus.Misalign_o), 32'd0);
    step(); checkOutput("free run 1", bus.PC_F, 32'h4);
    step(); checkOutput("free run 2", bus.PC_F, 32'h8);
    step(); checkOutput("free run 3", bus.PC_F, 32'hC);
    checkOutput("free run cnt", 32'(bus.RedirectCnt_o), 32'd0);
    step(); checkOutput("free run 4", bus.PC_F, 32'h10);

    // Redirect overrides stall
    applyStimulus(1, 2'b01, 32'h200, 0, 0, 0, 0, 0);
    #1 checkOutput("branch Flush_o", 32'(bus.Flush_o), 32'd1);
    step();
    checkOutput("branch PC_F", bus.PC_F, 32'h200);
    checkOutput("branch model PC", mPc, 32'h200);
    checkOutput("branch cnt", 32'(bus.RedirectCnt_o), 32'd1);

    // JALR clears bit0, bit1 set -> misaligned flag
    applyStimulus(0, 2'b10, 0, 32'h303, 0, 0, 0, 0);
    step();
    checkOutput("jalr PC_F", bus.PC_F, 32'h302);
    checkOutput("jalr Misalign_o", 32'(bus.Misalign_o), 32'd1);

    // Trap beats PCSrc
    applyStimulus(0, 2'b01, 32'h555, 0, 1, 0, 0, 0);
    step();
    checkOutput("trap PC_F", bus.PC_F, 32'h100);
    checkOutput("trap Misalign_o", 32'(bus.Misalign_o), 32'd0);

    // RAS overflow and drain
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(0, 2'b00, 0, 0, 0, 1, 0, 32'(i * 16));
      step();
    end
    checkOutput("ras overflow top", bus.RasTop_F, 32'h50);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 1, 0);
    step(); checkOutput("ras pop 1", bus.RasTop_F, 32'h40);
    step(); checkOutput("ras pop 2", bus.RasTop_F, 32'h30);
    step(); checkOutput("ras pop 3", bus.RasTop_F, 32'h20);
    step(); checkOutput("ras pop 4 valid", 32'(bus.RasValid_F), 32'd0);
    step(); checkOutput("ras pop empty valid", 32'(bus.RasValid_F), 32'd0);
    checkOutput("ras pop empty top", bus.RasTop_F, 32'h0);

    // Co-routine push+pop replaces top
    applyStimulus(0, 2'b00, 0, 0, 0, 1, 0, 32'hA0);
    step(); checkOutput("ras push A0", bus.RasTop_F, 32'hA0);
    applyStimulus(0, 2'b00, 0, 0, 0, 1, 1, 32'hB0);
    step(); checkOutput("ras swap top", bus.RasTop_F, 32'hB0);
    checkOutput("model ras depth", 32'(mRas.size()), 32'd1);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 1, 0);
    step(); checkOutput("ras swap count1", 32'(bus.RasValid_F), 32'd0);

    // PC wrap
    applyStimulus(0, 2'b01, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    step();
    checkOutput("wrap PC_F", bus.PC_F, 32'hFFFF_FFFC);
    checkOutput("wrap PCPlus4_F", bus.PCPlus4_F, 32'h0);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0);
    step(); checkOutput("wrap next PC_F", bus.PC_F, 32'h0);

    // Fifth redirect saturates the 2-bit counter
    applyStimulus(0, 2'b01, 32'h40, 0, 0, 0, 0, 0);
    step();
    checkOutput("cnt16 after 5", 32'(bus.RedirectCnt_o), 32'd5);
    checkOutput("cnt2 saturated", 32'(bus2.RedirectCnt_o), 32'd3);

    // Reserved source: sequential, no flush
    applyStimulus(0, 2'b11, 32'h999, 32'h777, 0, 0, 0, 0);
    #1 checkOutput("reserved Flush_o", 32'(bus.Flush_o), 32'd0);
    step(); checkOutput("reserved PC_F", bus.PC_F, 32'h44);

    // Randomised traffic with an asynchronous reset in the middle
    for (int i = 0; i < 300; i++) begin
      if (i == 150) pulseReset();
      applyStimulus($urandom_range(0, 9) < 3, 2'($urandom_range(0, 3)),
                    $urandom, $urandom, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                    $urandom);
      step();
    end

    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0);
    step();
    pulseReset();
    step();
    checkOutput("post reset PC_F", bus.PC_F, RESET_VEC + 32'd4);
    @(negedge clk);
    #1;
    compareEn = 0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
